// File: rtl/if_prefetch_unit.sv
// Instruction prefetch stage: runs a fetch PC ahead of decode, issues
// sequential instruction-memory requests and buffers {PC, instruction}
// pairs in a DEPTH-entry FIFO. Exception/branch redirects flush the FIFO
// and restart fetch at the (word-aligned) target after one dead cycle.
module if_prefetch_unit #(
    parameter int unsigned       WIDTH    = 64,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                         p_clk,
    input  logic                         p_rst_l,
    input  logic [WIDTH-1:0]             p_IF_ExceptionAddress,
    input  logic                         p_IF_ExceptionSrc,
    input  logic [WIDTH-1:0]             p_IF_BranchAddress,
    input  logic                         p_IF_PCSrc,
    input  logic [INST_W-1:0]            p_IF_INST_MemDataIn,
    input  logic                         p_IF_INST_MemWait,
    output logic [WIDTH-1:0]             p_IF_INST_MemAddress,
    output logic                         p_IF_INST_MemRead,
    input  logic                         p_IF_Ready,
    output logic                         p_IF_Valid,
    output logic [INST_W-1:0]            p_IF_Instruction,
    output logic [WIDTH-1:0]             p_IF_PC_Counter,
    output logic                         p_IF_Stall,
    output logic [$clog2(DEPTH+1)-1:0]   p_IF_Count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [WIDTH-1:0]  fetch_pc;
    logic [CW-1:0]     count;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic              redirect_pending;

    logic [WIDTH-1:0]  pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic              redirect_in;
    logic [WIDTH-1:0]  target;
    logic              mem_read;
    logic              accept;
    logic              pop;
    logic              valid;

    assign redirect_in = p_IF_ExceptionSrc | p_IF_PCSrc;
    assign target      = (p_IF_ExceptionSrc ? p_IF_ExceptionAddress : p_IF_BranchAddress)
                         & ~WIDTH'(3);
    assign valid       = (count != '0);
    assign pop         = valid & p_IF_Ready;

    // Debug FSM state register
    always_ff @(posedge p_clk or negedge p_rst_l) begin
        if (!p_rst_l) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state plus request gating; full check uses registered count only
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        accept     = 1'b0;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect_in) state_next = REDIR;
            REDIR:   if (!redirect_in) state_next = RUN;
            default: state_next = BOOT;
        endcase
        mem_read = p_rst_l & (state != BOOT) & ~redirect_pending & ~redirect_in
                   & (count < FULL);
        accept   = mem_read & ~p_IF_INST_MemWait;
    end

    // Fetch PC, FIFO pointers, occupancy and redirect bookkeeping
    always_ff @(posedge p_clk or negedge p_rst_l) begin
        if (!p_rst_l) begin
            fetch_pc         <= RESET_PC;
            count            <= '0;
            wptr             <= '0;
            rptr             <= '0;
            redirect_pending <= 1'b0;
        end else begin
            redirect_pending <= redirect_in;
            if (redirect_in) begin
                fetch_pc <= target;
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + WIDTH'(4);
                    wptr     <= (wptr == LAST) ? '0 : wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
                end
                count <= count + CW'(accept) - CW'(pop);
            end
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head
    always_ff @(posedge p_clk) begin
        if (accept) begin
            pc_mem[wptr]   <= fetch_pc;
            inst_mem[wptr] <= p_IF_INST_MemDataIn;
        end
    end

    // Output drive; head fields read as zero whenever the FIFO is empty
    always_comb begin
        p_IF_INST_MemAddress = fetch_pc;
        p_IF_INST_MemRead    = mem_read;
        p_IF_Valid           = valid;
        p_IF_Stall           = ~valid;
        p_IF_Count           = count;
        p_IF_Instruction     = valid ? inst_mem[rptr] : '0;
        p_IF_PC_Counter      = valid ? pc_mem[rptr]   : '0;
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_if_prefetch_unit;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic              p_clk;
    logic              p_rst_l;
    logic [63:0]       exc_addr;
    logic              exc_src;
    logic [63:0]       br_addr;
    logic              pc_src;
    logic [31:0]       mem_data;
    logic              mem_wait;
    logic [63:0]       mem_addr;
    logic              mem_read;
    logic              ready;
    logic              valid;
    logic [31:0]       instr;
    logic [63:0]       pc_out;
    logic              stall;
    logic [2:0]        count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc      = RST_PC;
    bit          m_pending = 1'b0;
    bit          m_boot    = 1'b1;

    if_prefetch_unit #(
        .WIDTH(WIDTH),
        .INST_W(INST_W),
        .DEPTH(DEPTH),
        .RESET_PC(RST_PC)
    ) dut (
        .p_clk(p_clk),
        .p_rst_l(p_rst_l),
        .p_IF_ExceptionAddress(exc_addr),
        .p_IF_ExceptionSrc(exc_src),
        .p_IF_BranchAddress(br_addr),
        .p_IF_PCSrc(pc_src),
        .p_IF_INST_MemDataIn(mem_data),
        .p_IF_INST_MemWait(mem_wait),
        .p_IF_INST_MemAddress(mem_addr),
        .p_IF_INST_MemRead(mem_read),
        .p_IF_Ready(ready),
        .p_IF_Valid(valid),
        .p_IF_Instruction(instr),
        .p_IF_PC_Counter(pc_out),
        .p_IF_Stall(stall),
        .p_IF_Count(count)
    );

    // Instruction memory contents are a fixed function of the address
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    assign mem_data = mem_f(mem_addr);

    initial begin
        p_clk = 1'b0;
        forever #5 p_clk = ~p_clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_read_f();
        return p_rst_l && !m_boot && !m_pending && !(exc_src || pc_src)
               && (q.size() < DEPTH);
    endfunction

    // Reference model: advances at each clock edge, cleared by async reset
    initial begin
        forever begin
            @(posedge p_clk or negedge p_rst_l);
            if (!p_rst_l) begin
                q.delete();
                m_pc      = RST_PC;
                m_pending = 1'b0;
                m_boot    = 1'b1;
            end else begin
                bit acc;
                bit pp;
                acc = exp_read_f() && !mem_wait;
                pp  = (q.size() != 0) && ready;
                if (exc_src || pc_src) begin
                    q.delete();
                    m_pc      = (exc_src ? exc_addr : br_addr) & ~64'h3;
                    m_pending = 1'b1;
                end else begin
                    if (pp) void'(q.pop_front());
                    if (acc) begin
                        q.push_back('{pc: m_pc, inst: mem_f(m_pc)});
                        m_pc = m_pc + 64'd4;
                    end
                    m_pending = 1'b0;
                end
                m_boot = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    initial begin
        forever begin
            @(negedge p_clk);
            chk("mem_read", mem_read, exp_read_f());
            chk("mem_addr", mem_addr, m_pc);
            chk("valid", valid, q.size() != 0);
            chk("stall", stall, q.size() == 0);
            chk("count", count, 64'(q.size()));
            if (q.size() != 0) begin
                chk("head_pc", pc_out, q[0].pc);
                chk("head_inst", instr, q[0].inst);
            end else if (!p_rst_l) begin
                chk("rst_pc", pc_out, 64'h0);
                chk("rst_inst", instr, 64'h0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic redirect_br(input logic [63:0] a, input logic rdy);
        @(posedge p_clk); #1;
        pc_src  = 1'b1;
        br_addr = a;
        ready   = rdy;
        @(posedge p_clk); #1;
        pc_src  = 1'b0;
    endtask

    initial begin
        bit found;
        p_rst_l  = 1'b0;
        exc_addr = '0;
        exc_src  = 1'b0;
        br_addr  = '0;
        pc_src   = 1'b0;
        mem_wait = 1'b0;
        ready    = 1'b1;

        // Reset state
        #2;
        chk("r_read", mem_read, 0);
        chk("r_addr", mem_addr, 64'h0);
        chk("r_valid", valid, 0);
        chk("r_stall", stall, 1);
        chk("r_count", count, 0);
        chk("r_inst", instr, 0);
        chk("r_pc", pc_out, 0);
        @(posedge p_clk); #1;
        p_rst_l = 1'b1;

        // Sequential fetch from reset
        @(negedge p_clk); chk("boot_noread", mem_read, 0);
        @(negedge p_clk); chk("s1_read", mem_read, 1); chk("s1_addr", mem_addr, 64'h0);
        @(negedge p_clk); chk("s1_pc0", pc_out, 64'h0); chk("s1_i0", instr, 64'h5A5A0000);
        chk("s1_addr4", mem_addr, 64'h4);
        @(negedge p_clk); chk("s1_pc4", pc_out, 64'h4); chk("s1_i4", instr, 64'h5A5A0004);
        @(negedge p_clk); chk("s1_pc8", pc_out, 64'h8); chk("s1_addrC", mem_addr, 64'hC);

        // Decode stalled: FIFO fills to DEPTH then drains in order
        redirect_br(64'h0, 1'b0);
        repeat (10) begin @(posedge p_clk); #1; end
        @(negedge p_clk);
        chk("s2_count", count, 4); chk("s2_read", mem_read, 0);
        chk("s2_addr", mem_addr, 64'h10); chk("s2_pc0", pc_out, 64'h0);
        #1 ready = 1'b1;
        @(negedge p_clk); chk("s2_pc4", pc_out, 64'h4); chk("s2_cnt3", count, 3);
        chk("s2_addr10", mem_addr, 64'h10);
        @(negedge p_clk); chk("s2_pc8", pc_out, 64'h8);
        @(negedge p_clk); chk("s2_pcC", pc_out, 64'hC);
        @(negedge p_clk); chk("s2_pc10", pc_out, 64'h10);

        // Memory wait holds the request at 0x20
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge p_clk);
            if (mem_addr == 64'h20 && mem_read) found = 1'b1;
        end
        if (!found) begin
            n_cmp++; n_err++;
            $display("FAIL s3_search: got no request at 0x20 expected one within 64 cycles");
        end
        #1 mem_wait = 1'b1; ready = 1'b0;
        repeat (3) begin
            @(negedge p_clk); chk("s3_hold_addr", mem_addr, 64'h20); chk("s3_hold_read", mem_read, 1);
        end
        #1 mem_wait = 1'b0;
        @(negedge p_clk); chk("s3_next_addr", mem_addr, 64'h24);

        // Exception and branch together: exception wins, old entries flushed
        redirect_br(64'h40, 1'b0);
        @(negedge p_clk);
        chk("s4_flush_valid", valid, 0); chk("s4_flush_cnt", count, 0);
        chk("s4_pend_read", mem_read, 0); chk("s4_addr40", mem_addr, 64'h40);
        repeat (4) begin @(posedge p_clk); #1; end
        @(negedge p_clk); chk("s4_cnt3", count, 3); chk("s4_addr4C", mem_addr, 64'h4C);
        #1;
        exc_src = 1'b1; exc_addr = 64'h180;
        pc_src  = 1'b1; br_addr  = 64'h400;
        ready   = 1'b1;
        #1 chk("s4_redir_noread", mem_read, 0);
        @(posedge p_clk); #1;
        exc_src = 1'b0; pc_src = 1'b0;
        @(negedge p_clk); chk("s4_valid0", valid, 0); chk("s4_count0", count, 0);
        chk("s4_pending_read", mem_read, 0);
        @(negedge p_clk); chk("s4_read180", mem_read, 1); chk("s4_addr180", mem_addr, 64'h180);
        @(negedge p_clk); chk("s4_pc180", pc_out, 64'h180); chk("s4_i180", instr, 64'h5A5A0180);

        // Misaligned branch target is word-aligned
        redirect_br(64'h1003, 1'b1);
        @(negedge p_clk); chk("s5_addr", mem_addr, 64'h1000); chk("s5_valid", valid, 0);
        @(negedge p_clk); chk("s5_read", mem_read, 1); chk("s5_addr2", mem_addr, 64'h1000);
        @(negedge p_clk); chk("s5_pc", pc_out, 64'h1000);

        // Fetch PC wraps past the top of the address space
        redirect_br(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        @(negedge p_clk); chk("s6_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge p_clk); chk("s6_read", mem_read, 1);
        @(negedge p_clk); chk("s6_wrap", mem_addr, 64'h0);
        chk("s6_pc", pc_out, 64'hFFFF_FFFF_FFFF_FFFC); chk("s6_inst", instr, 64'hA5A5FFFC);

        // Asynchronous reset mid-operation with entries buffered and a wait
        redirect_br(64'h100, 1'b0);
        repeat (3) begin @(posedge p_clk); #1; end
        @(negedge p_clk); chk("s7_cnt2", count, 2);
        #1 mem_wait = 1'b1;
        #1 p_rst_l = 1'b0;
        #1;
        chk("s7_read", mem_read, 0); chk("s7_addr", mem_addr, RST_PC);
        chk("s7_valid", valid, 0); chk("s7_stall", stall, 1);
        chk("s7_count", count, 0); chk("s7_inst", instr, 0); chk("s7_pc", pc_out, 0);
        #1 p_rst_l = 1'b1;
        @(negedge p_clk); chk("s7_rel_addr", mem_addr, RST_PC); chk("s7_rel_valid", valid, 0);
        chk("s7_rel_read", mem_read, 1);
        #1 mem_wait = 1'b0; ready = 1'b1;
        @(negedge p_clk); chk("s7_first_pc", pc_out, RST_PC); chk("s7_first_v", valid, 1);
        chk("s7_first_inst", instr, 64'h5A5A0000);

        repeat (4) @(negedge p_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised next-generation instruction fetch stage for the MIPS64 core.
- Runs a fetch PC ahead of decode and issues sequential requests to instruction memory.
- Buffers returned {PC, instruction} pairs in a DEPTH-entry FIFO, so short decode stalls do not cost fetch bandwidth and memory wait cycles are hidden.
- Branch and exception redirects flush the buffer and restart fetch at the new target.

Parameters:
- WIDTH, 64, address/PC width in bits.
- INST_W, 32, instruction word width in bits.
- DEPTH, 4, prefetch FIFO entries; legal range 2..16.
- RESET_PC, 0, fetch PC loaded on reset; bits [1:0] must be 0.

Ports:
- p_clk  in  1  clock, rising edge.
- p_rst_l  in  1  reset, asynchronous, active-low.
- p_IF_ExceptionAddress  in  WIDTH  exception vector.
- p_IF_ExceptionSrc  in  1  exception redirect request.
- p_IF_BranchAddress  in  WIDTH  branch/jump target.
- p_IF_PCSrc  in  1  branch redirect request.
- p_IF_INST_MemDataIn  in  INST_W  instruction data; valid in any cycle with MemRead=1 and MemWait=0.
- p_IF_INST_MemWait  in  1  memory not ready; holds the current request.
- p_IF_INST_MemAddress  out  WIDTH  request address.
- p_IF_INST_MemRead  out  1  request valid.
- p_IF_Ready  in  1  decode accepts the head entry this cycle.
- p_IF_Valid  out  1  head entry valid.
- p_IF_Instruction  out  INST_W  head instruction.
- p_IF_PC_Counter  out  WIDTH  PC of head instruction.
- p_IF_Stall  out  1  FIFO empty (= ~p_IF_Valid).
- p_IF_Count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (asynchronous, p_rst_l=0):
  - fetch_pc=RESET_PC, count=0, read/write pointers=0, redirect_pending=0.
  - Outputs: MemRead=0, MemAddress=RESET_PC, Valid=0, Stall=1, Count=0, Instruction=0, PC_Counter=0.
  - Reset asserted mid-operation discards all buffered entries and any in-flight request.
- Request:
  - MemAddress = fetch_pc at all times.
  - MemRead = p_rst_l & ~redirect_pending & ~redirect_in & (count<DEPTH), where redirect_in = ExceptionSrc|PCSrc.
  - The full check uses registered count only; no request is made when full, even if a pop occurs in the same cycle.
- Accept: accept = MemRead & ~MemWait. On the next edge:
  - write {fetch_pc, MemDataIn} at wptr;
  - wptr advances mod DEPTH;
  - fetch_pc = fetch_pc+4, wrapping mod 2^WIDTH (all-ones-minus-3 wraps to 0).
- MemWait=1 while MemRead=1: fetch_pc and FIFO are unchanged; the same address is re-presented next cycle.
- Pop: pop = Valid & Ready. rptr advances mod DEPTH.
  - Head outputs come combinationally from registered storage.
  - Ready while Valid=0 has no effect.
- Occupancy: count_next = count + accept - pop.
  - A simultaneous accept and pop leaves count unchanged.
  - count never exceeds DEPTH and never underflows.
- Latency: an accept in cycle N makes the entry visible at the head in cycle N+1 when the FIFO was empty. Sustained throughput with MemWait=0 and Ready=1 is one instruction per cycle.
- Redirect (ExceptionSrc or PCSrc high in cycle N):
  - target = ExceptionSrc ? ExceptionAddress : BranchAddress; exception has priority when both are high.
  - target[1:0] is forced to 00.
  - In cycle N: MemRead=0, so memory data is ignored; any pop is still honoured.
  - At edge N: FIFO flushed (count=0, pointers=0), fetch_pc=target, redirect_pending=1.
  - Cycle N+1: redirect_pending=1, MemRead=0, Valid=0; redirect_pending clears at the end of N+1.
  - Cycle N+2: first request to target. A redirect arriving in N+1 restarts the sequence with the new target.
- FSM for debug visibility (not exported):
  - BOOT: first cycle after reset release, no request; goes to RUN.
  - RUN: fetching; goes to REDIR on redirect_in.
  - REDIR: the pending cycle; goes to RUN unless redirect_in is high again.
  - MemRead is additionally gated off in BOOT.

Test Plan:
- Reset release, MemWait=0, Ready=1, RESET_PC=0: MemRead first high in cycle 2. Requests go to 0x0, 0x4, 0x8. Valid rises one cycle after the first accept; PC_Counter sequence is 0x0, 0x4, 0x8 with matching instruction data.
- Ready=0 for 10 cycles, DEPTH=4: exactly 4 accepts (PCs 0x0–0xC). Count=4, MemRead=0, MemAddress holds 0x10. Raising Ready drains 0x0, 0x4, 0x8, 0xC in order while fetch resumes at 0x10.
- MemWait=1 for 3 cycles at PC 0x20: MemAddress stays 0x20 and no push occurs. On release, one push of 0x20 follows; no duplicate and no skip.
- With 3 entries buffered, ExceptionSrc=1 (0x180) and PCSrc=1 (0x400) in the same cycle: the next cycle shows Valid=0 and Count=0. The following cycle shows MemAddress=0x180, MemRead=1. The first popped PC is 0x180; none of the old entries or 0x400 appear.
- PCSrc=1 with BranchAddress=0x1003: fetch restarts at 0x1000.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC (WIDTH=64): after one accept, MemAddress=0x0 and the entry's PC is 0xFFFF_FFFF_FFFF_FFFC.
- p_rst_l pulsed low while Count=2 and MemWait=1: outputs go to their reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC with no stale entries.
